// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with grant hold, optional maximum hold time and zero-gap handover.
// Grant, valid, index and hold count are all taken from registered state.
module rr_arbiter_hold #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(NUM_REQ),
  localparam int CW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_vld,
  output logic [IDW-1:0]     gnt_id,
  output logic [CW-1:0]      busy_cnt
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CW-1:0]  HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NUM_REQ - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [IDW-1:0] id_nxt;
  logic [CW-1:0]  cnt_nxt;
  logic [IDW-1:0] after_owner;
  logic           release_own;

  // Circular search from p: lowest set bit at or above p, else lowest set bit below p.
  function automatic logic [IDW-1:0] sel(input logic [NUM_REQ-1:0] v, input logic [IDW-1:0] p);
    logic [IDW-1:0] hi, lo;
    logic           hi_hit, lo_hit;
    hi     = '0;
    lo     = '0;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (v[j] && (j >= 32'(p)) && !hi_hit) begin
        hi     = IDW'(j);
        hi_hit = 1'b1;
      end
      if (v[j] && (j < 32'(p)) && !lo_hit) begin
        lo     = IDW'(j);
        lo_hit = 1'b1;
      end
    end
    return hi_hit ? hi : lo;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_id   <= '0;
      busy_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_id   <= id_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    after_owner = (gnt_id == LAST_IDX) ? '0 : gnt_id + 1'b1;
    release_own = !req[gnt_id] || ((MAX_HOLD != 0) && (busy_cnt == HOLD_LAST));
  end

  // Searching from the owner's successor puts a timed-out owner last in line.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    id_nxt    = gnt_id;
    cnt_nxt   = busy_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = OWN;
          id_nxt    = sel(req, ptr);
          cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (!release_own) begin
          if (busy_cnt != '1) cnt_nxt = busy_cnt + 1'b1;
        end else begin
          ptr_nxt = after_owner;
          cnt_nxt = '0;
          if (|req) id_nxt    = sel(req, after_owner);
          else      state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt     = '0;
    gnt_vld = (state == OWN);
    if (state == OWN) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Self-checking bench for rr_arbiter_hold: a 4-way instance with hold limit 4 and a
// 5-way instance with unlimited hold, checked cycle by cycle through expectation queues.
module tb_rr_arbiter_hold;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] req_a, gnt_a;
  logic       vld_a;
  logic [1:0] id_a;
  logic [2:0] cnt_a;
  logic [4:0] req_b, gnt_b;
  logic       vld_b;
  logic [2:0] id_b;
  logic [0:0] cnt_b;

  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  rr_arbiter_hold #(.NUM_REQ(4), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .req(req_a),
    .gnt(gnt_a), .gnt_vld(vld_a), .gnt_id(id_a), .busy_cnt(cnt_a)
  );

  rr_arbiter_hold #(.NUM_REQ(5), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b),
    .gnt(gnt_b), .gnt_vld(vld_b), .gnt_id(id_b), .busy_cnt(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] pa(input logic [3:0] g, input logic v, input logic [1:0] id, input logic [2:0] c);
    return {g, v, id, c};
  endfunction

  function automatic logic [9:0] pb(input logic [4:0] g, input logic v, input logic [2:0] id, input logic c);
    return {g, v, id, c};
  endfunction

  task automatic test_reset;
    logic [9:0] e;
    rst_a = 1'b0; rst_b = 1'b0; req_a = '0; req_b = '0;
    #2;
    exp_a.push_back(pa(4'b0000, 1'b0, 2'd0, 3'd0));
    exp_b.push_back(pb(5'b00000, 1'b0, 3'd0, 1'b0));
    e = exp_a.pop_front();
    n_chk++;
    if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL reset_a: got %h expected %h", {gnt_a, vld_a, id_a, cnt_a}, e);
    else n_pass++;
    e = exp_b.pop_front();
    n_chk++;
    if ({gnt_b, vld_b, id_b, cnt_b} !== e) $display("FAIL reset_b: got %h expected %h", {gnt_b, vld_b, id_b, cnt_b}, e);
    else n_pass++;
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  // Sole requester 2: counts 0..3, re-granted to itself on timeout, then drops.
  task automatic test_hold_timeout;
    logic [9:0] e;
    for (int unsigned i = 0; i < 7; i++) begin
      req_a = (i < 6) ? 4'b0100 : 4'b0000;
      if (i < 6) exp_a.push_back(pa(4'b0100, 1'b1, 2'd2, 3'(i % 4)));
      else       exp_a.push_back(pa(4'b0000, 1'b0, 2'd2, 3'd0));
      @(posedge clk); #1;
      e = exp_a.pop_front();
      n_chk++;
      if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL hold_timeout step %0d: got %h expected %h", i, {gnt_a, vld_a, id_a, cnt_a}, e);
      else n_pass++;
    end
  endtask

  // Idle with ptr=3 and gnt_id held at 2; reassert gives 1-cycle latency, search from 3 lands on 1.
  task automatic test_idle_latency;
    logic [3:0] rq[4];
    logic [9:0] ex[4];
    logic [9:0] e;
    rq = '{4'b0000, 4'b0110, 4'b0110, 4'b0000};
    ex = '{pa(4'b0000, 1'b0, 2'd2, 3'd0), pa(4'b0010, 1'b1, 2'd1, 3'd0),
           pa(4'b0010, 1'b1, 2'd1, 3'd1), pa(4'b0000, 1'b0, 2'd1, 3'd0)};
    for (int unsigned i = 0; i < 4; i++) begin
      req_a = rq[i];
      exp_a.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_a.pop_front();
      n_chk++;
      if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL idle_latency step %0d: got %h expected %h", i, {gnt_a, vld_a, id_a, cnt_a}, e);
      else n_pass++;
    end
  endtask

  task automatic test_rotate;
    logic [9:0] e;
    int unsigned own;
    rst_a = 1'b0; req_a = '0;
    #2;
    rst_a = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      req_a = 4'b1111;
      own = (i / 4) % 4;
      exp_a.push_back(pa(4'(1 << own), 1'b1, 2'(own), 3'(i % 4)));
      @(posedge clk); #1;
      e = exp_a.pop_front();
      n_chk++;
      if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL rotate step %0d: got %h expected %h", i, {gnt_a, vld_a, id_a, cnt_a}, e);
      else n_pass++;
    end
  endtask

  task automatic test_drop_handover;
    logic [3:0] rq[9];
    logic [9:0] ex[9];
    logic [9:0] e;
    rq = '{4'b0010, 4'b1011, 4'b1001, 4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b1010};
    ex = '{pa(4'b0010, 1'b1, 2'd1, 3'd0), pa(4'b0010, 1'b1, 2'd1, 3'd1),
           pa(4'b1000, 1'b1, 2'd3, 3'd0), pa(4'b0001, 1'b1, 2'd0, 3'd0),
           pa(4'b0001, 1'b1, 2'd0, 3'd1), pa(4'b0000, 1'b0, 2'd0, 3'd0),
           pa(4'b1000, 1'b1, 2'd3, 3'd0), pa(4'b0000, 1'b0, 2'd3, 3'd0),
           pa(4'b0010, 1'b1, 2'd1, 3'd0)};
    rst_a = 1'b0; req_a = '0;
    #2;
    rst_a = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      req_a = rq[i];
      exp_a.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_a.pop_front();
      n_chk++;
      if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL drop_handover step %0d: got %h expected %h", i, {gnt_a, vld_a, id_a, cnt_a}, e);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset;
    logic [9:0] e;
    int unsigned own;
    rst_a = 1'b0; req_a = '0;
    #2;
    rst_a = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      req_a = 4'b1111;
      own = i / 4;
      exp_a.push_back(pa(4'(1 << own), 1'b1, 2'(own), 3'(i % 4)));
      @(posedge clk); #1;
      e = exp_a.pop_front();
      n_chk++;
      if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL async_pre step %0d: got %h expected %h", i, {gnt_a, vld_a, id_a, cnt_a}, e);
      else n_pass++;
    end
    #2;
    rst_a = 1'b0;
    #1;
    exp_a.push_back(pa(4'b0000, 1'b0, 2'd0, 3'd0));
    e = exp_a.pop_front();
    n_chk++;
    if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL async_clear: got %h expected %h", {gnt_a, vld_a, id_a, cnt_a}, e);
    else n_pass++;
    exp_a.push_back(pa(4'b0000, 1'b0, 2'd0, 3'd0));
    @(posedge clk); #1;
    e = exp_a.pop_front();
    n_chk++;
    if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL async_held: got %h expected %h", {gnt_a, vld_a, id_a, cnt_a}, e);
    else n_pass++;
    #1;
    rst_a = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      exp_a.push_back(pa(4'b0001, 1'b1, 2'd0, 3'(i)));
      @(posedge clk); #1;
      e = exp_a.pop_front();
      n_chk++;
      if ({gnt_a, vld_a, id_a, cnt_a} !== e) $display("FAIL async_post step %0d: got %h expected %h", i, {gnt_a, vld_a, id_a, cnt_a}, e);
      else n_pass++;
    end
    req_a = '0;
  endtask

  // Five requesters, no hold limit: owner 0 keeps the grant with a saturated count until it drops.
  task automatic test_unlimited;
    logic [4:0] rq[16];
    logic [9:0] ex[16];
    logic [9:0] e;
    for (int unsigned i = 0; i < 10; i++) begin
      rq[i] = 5'b11111;
      ex[i] = pb(5'b00001, 1'b1, 3'd0, (i == 0) ? 1'b0 : 1'b1);
    end
    rq[10] = 5'b11110; ex[10] = pb(5'b00010, 1'b1, 3'd1, 1'b0);
    rq[11] = 5'b11110; ex[11] = pb(5'b00010, 1'b1, 3'd1, 1'b1);
    rq[12] = 5'b10100; ex[12] = pb(5'b00100, 1'b1, 3'd2, 1'b0);
    rq[13] = 5'b10000; ex[13] = pb(5'b10000, 1'b1, 3'd4, 1'b0);
    rq[14] = 5'b00011; ex[14] = pb(5'b00001, 1'b1, 3'd0, 1'b0);
    rq[15] = 5'b00000; ex[15] = pb(5'b00000, 1'b0, 3'd0, 1'b0);
    rst_b = 1'b0; req_b = '0;
    #2;
    rst_b = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      req_b = rq[i];
      exp_b.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_b.pop_front();
      n_chk++;
      if ({gnt_b, vld_b, id_b, cnt_b} !== e) $display("FAIL unlimited step %0d: got %h expected %h", i, {gnt_b, vld_b, id_b, cnt_b}, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_hold_timeout();
    test_idle_latency();
    test_rotate();
    test_drop_handover();
    test_async_reset();
    test_unlimited();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
